operand_stage: RTL and testbench
================================

# operand_stage

Register-read/operand-fetch stage of the MIPS pipeline, directly downstream of the register bank. Accepts decoded source/destination fields from ID, drives the bank's read addresses and `memread`, captures `doa`/`dob` one cycle later, and applies EX/MEM/WB forwarding. Also detects load-use hazards and presents resolved operands to EX through a valid/ready pipeline register.

## Interface
- `DIR`, default 5: register address width.
- `BUS`, default 32: data width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `id_valid`  in  1: ID presents an instruction.
- `id_ready`  out  1: stage accepts the instruction this cycle.
- `id_rs`, `id_rt`  in  DIR: source register addresses.
- `id_use_rs`, `id_use_rt`  in  1: the instruction actually reads that source.
- `id_rd`  in  DIR: destination address.
- `id_we`  in  1: instruction writes `id_rd`.
- `id_is_load`  in  1: instruction is a load.
- `rf_da`, `rf_db`  out  DIR: bank read addresses.
- `rf_memread`  out  1: bank read enable.
- `rf_doa`, `rf_dob`  in  BUS: bank read data, valid one cycle after `rf_memread`.
- `ex_fwd_we`, `ex_fwd_load`  in  1: EX writes a register / EX holds a load.
- `ex_fwd_addr`  in  DIR; `ex_fwd_data`  in  BUS: EX result.
- `mem_fwd_we`  in  1; `mem_fwd_addr`  in  DIR; `mem_fwd_data`  in  BUS: MEM result.
- `wb_we`  in  1; `wb_addr`  in  DIR; `wb_data`  in  BUS: WB write; these are the same signals driving the bank write port.
- `ex_valid`  out  1; `ex_ready`  in  1: handshake to EX.
- `ex_opa`, `ex_opb`  out  BUS: resolved operands.
- `ex_rd`  out  DIR; `ex_we`, `ex_is_load`  out  1: passed-through metadata.
- `hz_count`  out  16: saturating count of load-use stall cycles.

## Operation
- Two internal stages.
  - **S1:** metadata captured at the issue edge; bank data arrives in this cycle.
  - **S2:** the `ex_*` output register.
- **Issue:**
  - When `id_valid && id_ready`: `rf_da=id_rs`, `rf_db=id_rt`, `rf_memread=1`, S1 loads the metadata.
  - When S1 is valid and held: `rf_da/rf_db` = S1 rs/rt and `rf_memread=1`. The bank re-reads every held cycle, so WB writes made during a stall are picked up.
  - Otherwise `rf_memread=0`.
- **Forwarding** (per operand, in S1): priority EX > MEM > WB > bank.
  - A source matches when that source's `*_we` is set and its address is equal.
  - An EX match with `ex_fwd_load=1` is not forwarded; it is a hazard.
- **Hazard:** `hazard = s1_valid && ex_fwd_we && ex_fwd_load && ((id_use_rs_s1 && rs==ex_fwd_addr) || (id_use_rt_s1 && rt==ex_fwd_addr))`.
- **Advance and ready:**
  - `s2_free = !ex_valid || ex_ready`.
  - `s1_adv = s1_valid && !hazard && s2_free`.
  - `id_ready = !s1_valid || s1_adv`.
- **S2 update:**
  - If `s1_adv`: load the forwarded operands and metadata; `ex_valid=1`.
  - Else if `hazard && s2_free`: load a bubble (`ex_valid=0`; operands and metadata unchanged).
  - Else if `s2_free`: `ex_valid=0`.
  - Else hold.
- **`hz_count`:** increments on every cycle where `hazard` is 1; saturates at 0xFFFF.

## Timing
- Latency: 2 cycles from the ID accept edge to `ex_valid`. Throughput: 1 instruction/cycle without hazards.
- `id_ready` is combinational from `hazard`, `ex_valid` and `ex_ready`.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load has left EX and is forwarded from MEM.
- Hazard and downstream stall in the same cycle: both S1 and S2 hold; no bubble overwrites the held S2 content.
- WB write in the issue cycle is visible through the bank (negedge write, posedge read). A WB write in the S1 cycle is taken by forwarding.
- Reset (asynchronous, any time):
  - `ex_valid=0`, S1 valid=0.
  - `ex_opa`, `ex_opb`, `ex_rd`, `ex_we`, `ex_is_load`, `hz_count` = 0.
  - `rf_memread=0`.
  - In-flight instructions are discarded.

## Configuration
- `OPERAND_ZERO_REG_EN` defined:
  - Address 0 never matches any forwarding source or the hazard check.
  - An operand read from address 0 is forced to 0.
- Not defined: address 0 is an ordinary register in forwarding, hazard detection and operand selection.

## Structure
- Shared package `mips_pkg`:
  - `DIR`/`BUS` defaults.
  - Forward-select enum `FWD_RF`, `FWD_WB`, `FWD_MEM`, `FWD_EX`.
  - `HZ_COUNT_W=16`.
- Sub-module `fwd_mux`: one-operand priority compare/select returning data and select code. Instantiated twice (rs, rt).

## Test plan
- Issue `rs=3, rt=4` with bank `r3=0x11`, `r4=0x22`, no forwarding -> `ex_opa=0x11`, `ex_opb=0x22`, `ex_valid` 2 cycles after accept.
- EX writes `r5=0xAA` while MEM writes `r5=0xBB`; issue `rs=5` -> `ex_opa=0xAA` (EX priority).
- Load to `r7` in EX; next instruction uses `rs=7` -> exactly one bubble, `id_ready=0` for one cycle, `hz_count=1`, then `ex_opa` = MEM-forwarded load data.
- Hold `ex_ready=0` for 3 cycles while WB writes `r9=0x55`; S1 holds `rs=9` -> after release, `ex_opa=0x55` and no instruction is lost or duplicated.
- With `OPERAND_ZERO_REG_EN`: EX writes `r0=0xFF`; issue `rs=0` -> `ex_opa=0`. Without the macro -> `ex_opa=0xFF`.
- Assert `rst_n=0` with both stages full -> all outputs 0 and `ex_valid=0` immediately; after release the first new issue appears 2 cycles later.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS operand stage: width defaults, forward-select
// codes and the hazard counter helper.
package mips_pkg;

  localparam int DIR_DEFAULT = 5;
  localparam int BUS_DEFAULT = 32;
  localparam int HZ_COUNT_W  = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

  function automatic logic [HZ_COUNT_W-1:0] hz_sat_inc(input logic [HZ_COUNT_W-1:0] c);
    if (c == {HZ_COUNT_W{1'b1}}) return c;
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Bundle of all operand_stage signals: ID issue, register bank port,
// forwarding sources, EX handshake and debug observability.
interface operand_stage_if
  import mips_pkg::*;
#(
  parameter int DIR = DIR_DEFAULT,
  parameter int BUS = BUS_DEFAULT
);
  // Both handshakes: a transfer happens on a rising edge where valid && ready;
  // valid must not depend on ready, and the sender holds its payload until taken.
  logic                  id_valid;
  logic                  id_ready;
  logic [DIR-1:0]        id_rs;
  logic [DIR-1:0]        id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [DIR-1:0]        id_rd;
  logic                  id_we;
  logic                  id_is_load;

  logic [DIR-1:0]        rf_da;
  logic [DIR-1:0]        rf_db;
  logic                  rf_memread;
  logic [BUS-1:0]        rf_doa;
  logic [BUS-1:0]        rf_dob;

  logic                  ex_fwd_we;
  logic                  ex_fwd_load;
  logic [DIR-1:0]        ex_fwd_addr;
  logic [BUS-1:0]        ex_fwd_data;
  logic                  mem_fwd_we;
  logic [DIR-1:0]        mem_fwd_addr;
  logic [BUS-1:0]        mem_fwd_data;
  logic                  wb_we;
  logic [DIR-1:0]        wb_addr;
  logic [BUS-1:0]        wb_data;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [BUS-1:0]        ex_opa;
  logic [BUS-1:0]        ex_opb;
  logic [DIR-1:0]        ex_rd;
  logic                  ex_we;
  logic                  ex_is_load;
  logic [HZ_COUNT_W-1:0] hz_count;

  logic                  dbg_s1_valid;
  logic                  dbg_hazard;
  fwd_sel_e              dbg_sel_a;
  fwd_sel_e              dbg_sel_b;

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_we, id_is_load,
    output id_ready,
    output rf_da, rf_db, rf_memread,
    input  rf_doa, rf_dob,
    input  ex_fwd_we, ex_fwd_load, ex_fwd_addr, ex_fwd_data,
    input  mem_fwd_we, mem_fwd_addr, mem_fwd_data,
    input  wb_we, wb_addr, wb_data,
    output ex_valid, ex_opa, ex_opb, ex_rd, ex_we, ex_is_load, hz_count,
    input  ex_ready,
    output dbg_s1_valid, dbg_hazard, dbg_sel_a, dbg_sel_b
  );

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_we, id_is_load,
    input  id_ready,
    input  rf_da, rf_db, rf_memread,
    output rf_doa, rf_dob,
    output ex_fwd_we, ex_fwd_load, ex_fwd_addr, ex_fwd_data,
    output mem_fwd_we, mem_fwd_addr, mem_fwd_data,
    output wb_we, wb_addr, wb_data,
    input  ex_valid, ex_opa, ex_opb, ex_rd, ex_we, ex_is_load, hz_count,
    output ex_ready,
    input  dbg_s1_valid, dbg_hazard, dbg_sel_a, dbg_sel_b
  );

endinterface

// File: rtl/operand_stage_fwd_mux.sv
// One-operand forwarding select, priority EX > MEM > WB > bank.
// OPERAND_ZERO_REG_EN: register 0 never matches and always reads as zero.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DIR = DIR_DEFAULT,
  parameter int BUS = BUS_DEFAULT
) (
  input  logic [DIR-1:0] i_addr,
  input  logic           i_ex_we,
  input  logic           i_ex_load,
  input  logic [DIR-1:0] i_ex_addr,
  input  logic [BUS-1:0] i_ex_data,
  input  logic           i_mem_we,
  input  logic [DIR-1:0] i_mem_addr,
  input  logic [BUS-1:0] i_mem_data,
  input  logic           i_wb_we,
  input  logic [DIR-1:0] i_wb_addr,
  input  logic [BUS-1:0] i_wb_data,
  input  logic [BUS-1:0] i_rf_data,
  output logic [BUS-1:0] o_data,
  output fwd_sel_e       o_sel
);

  logic w_zero;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

`ifdef OPERAND_ZERO_REG_EN
  assign w_zero = (i_addr == '0);
`else
  assign w_zero = 1'b0;
`endif

  // A load still in EX has no data yet; the hazard logic stalls on it instead.
  assign w_ex_hit  = i_ex_we && !i_ex_load && (i_ex_addr == i_addr) && !w_zero;
  assign w_mem_hit = i_mem_we && (i_mem_addr == i_addr) && !w_zero;
  assign w_wb_hit  = i_wb_we && (i_wb_addr == i_addr) && !w_zero;

  always_comb begin
    o_sel  = FWD_RF;
    o_data = i_rf_data;
    if (w_ex_hit) begin
      o_sel  = FWD_EX;
      o_data = i_ex_data;
    end else if (w_mem_hit) begin
      o_sel  = FWD_MEM;
      o_data = i_mem_data;
    end else if (w_wb_hit) begin
      o_sel  = FWD_WB;
      o_data = i_wb_data;
    end
    if (w_zero) o_data = '0;
  end

endmodule

// File: rtl/operand_stage.sv
// Register-read / operand-fetch stage: bank read issue, S1 forwarding,
// load-use stall and the EX pipeline register. OPERAND_ZERO_REG_EN hardwires r0.
module operand_stage
  import mips_pkg::*;
#(
  parameter int DIR = DIR_DEFAULT,
  parameter int BUS = BUS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_stage_if.slave   bus
);

  logic                  r_s1_valid;
  logic [DIR-1:0]        r_s1_rs;
  logic [DIR-1:0]        r_s1_rt;
  logic [DIR-1:0]        r_s1_rd;
  logic                  r_s1_use_rs;
  logic                  r_s1_use_rt;
  logic                  r_s1_we;
  logic                  r_s1_is_load;

  logic                  r_ex_valid;
  logic [BUS-1:0]        r_ex_opa;
  logic [BUS-1:0]        r_ex_opb;
  logic [DIR-1:0]        r_ex_rd;
  logic                  r_ex_we;
  logic                  r_ex_is_load;
  logic [HZ_COUNT_W-1:0] r_hz_count;

  logic                  w_ex_load_rs;
  logic                  w_ex_load_rt;
  logic                  w_hazard;
  logic                  w_s2_free;
  logic                  w_s1_adv;
  logic                  w_id_ready;
  logic                  w_issue;
  logic [BUS-1:0]        w_opa;
  logic [BUS-1:0]        w_opb;
  fwd_sel_e              w_sel_a;
  fwd_sel_e              w_sel_b;
  logic                  w_rs_nz;
  logic                  w_rt_nz;

`ifdef OPERAND_ZERO_REG_EN
  assign w_rs_nz = (r_s1_rs != '0);
  assign w_rt_nz = (r_s1_rt != '0);
`else
  assign w_rs_nz = 1'b1;
  assign w_rt_nz = 1'b1;
`endif

  assign w_ex_load_rs = r_s1_use_rs && w_rs_nz && (r_s1_rs == bus.ex_fwd_addr);
  assign w_ex_load_rt = r_s1_use_rt && w_rt_nz && (r_s1_rt == bus.ex_fwd_addr);
  assign w_hazard     = r_s1_valid && bus.ex_fwd_we && bus.ex_fwd_load &&
                        (w_ex_load_rs || w_ex_load_rt);
  assign w_s2_free    = !r_ex_valid || bus.ex_ready;
  assign w_s1_adv     = r_s1_valid && !w_hazard && w_s2_free;
  assign w_id_ready   = !r_s1_valid || w_s1_adv;
  assign w_issue      = bus.id_valid && w_id_ready;

  // A held S1 keeps re-reading the bank so writes landing during a stall are seen.
  assign bus.rf_memread = w_issue || (r_s1_valid && !w_s1_adv);
  assign bus.rf_da      = w_issue ? bus.id_rs : r_s1_rs;
  assign bus.rf_db      = w_issue ? bus.id_rt : r_s1_rt;
  assign bus.id_ready   = w_id_ready;

  fwd_mux #(.DIR(DIR), .BUS(BUS)) u_fwd_a (
    .i_addr     (r_s1_rs),
    .i_ex_we    (bus.ex_fwd_we),
    .i_ex_load  (bus.ex_fwd_load),
    .i_ex_addr  (bus.ex_fwd_addr),
    .i_ex_data  (bus.ex_fwd_data),
    .i_mem_we   (bus.mem_fwd_we),
    .i_mem_addr (bus.mem_fwd_addr),
    .i_mem_data (bus.mem_fwd_data),
    .i_wb_we    (bus.wb_we),
    .i_wb_addr  (bus.wb_addr),
    .i_wb_data  (bus.wb_data),
    .i_rf_data  (bus.rf_doa),
    .o_data     (w_opa),
    .o_sel      (w_sel_a)
  );

  fwd_mux #(.DIR(DIR), .BUS(BUS)) u_fwd_b (
    .i_addr     (r_s1_rt),
    .i_ex_we    (bus.ex_fwd_we),
    .i_ex_load  (bus.ex_fwd_load),
    .i_ex_addr  (bus.ex_fwd_addr),
    .i_ex_data  (bus.ex_fwd_data),
    .i_mem_we   (bus.mem_fwd_we),
    .i_mem_addr (bus.mem_fwd_addr),
    .i_mem_data (bus.mem_fwd_data),
    .i_wb_we    (bus.wb_we),
    .i_wb_addr  (bus.wb_addr),
    .i_wb_data  (bus.wb_data),
    .i_rf_data  (bus.rf_dob),
    .o_data     (w_opb),
    .o_sel      (w_sel_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_rs      <= '0;
      r_s1_rt      <= '0;
      r_s1_rd      <= '0;
      r_s1_use_rs  <= 1'b0;
      r_s1_use_rt  <= 1'b0;
      r_s1_we      <= 1'b0;
      r_s1_is_load <= 1'b0;
    end else if (w_issue) begin
      r_s1_valid   <= 1'b1;
      r_s1_rs      <= bus.id_rs;
      r_s1_rt      <= bus.id_rt;
      r_s1_rd      <= bus.id_rd;
      r_s1_use_rs  <= bus.id_use_rs;
      r_s1_use_rt  <= bus.id_use_rt;
      r_s1_we      <= bus.id_we;
      r_s1_is_load <= bus.id_is_load;
    end else if (w_s1_adv) begin
      r_s1_valid   <= 1'b0;
    end
  end

  // A free S2 that receives nothing (including the load-use bubble) just drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_opa     <= '0;
      r_ex_opb     <= '0;
      r_ex_rd      <= '0;
      r_ex_we      <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (w_s1_adv) begin
      r_ex_valid   <= 1'b1;
      r_ex_opa     <= w_opa;
      r_ex_opb     <= w_opb;
      r_ex_rd      <= r_s1_rd;
      r_ex_we      <= r_s1_we;
      r_ex_is_load <= r_s1_is_load;
    end else if (w_s2_free) begin
      r_ex_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hz_count <= '0;
    end else if (w_hazard) begin
      r_hz_count <= hz_sat_inc(r_hz_count);
    end
  end

  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_opa       = r_ex_opa;
  assign bus.ex_opb       = r_ex_opb;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.ex_we        = r_ex_we;
  assign bus.ex_is_load   = r_ex_is_load;
  assign bus.hz_count     = r_hz_count;
  assign bus.dbg_s1_valid = r_s1_valid;
  assign bus.dbg_hazard   = w_hazard;
  assign bus.dbg_sel_a    = w_sel_a;
  assign bus.dbg_sel_b    = w_sel_b;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: bank model, transaction-level reference with
// directed scenarios followed by randomized traffic.
module tb_operand_stage;
  import mips_pkg::*;

  localparam int DIR = 5;
  localparam int BUS = 32;
  localparam int EW  = 2 * BUS + DIR + 2;
`ifdef OPERAND_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_stage_if #(.DIR(DIR), .BUS(BUS)) bus ();
  operand_stage #(.DIR(DIR), .BUS(BUS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [DIR-1:0] rs, rt, rd;
    logic           use_rs, use_rt, we, ld;
  } ins_t;

  ins_t           s1_q[$];
  logic [EW-1:0]  exp_q[$];
  logic [BUS-1:0] bank [2**DIR];
  logic [15:0]    hz_exp = '0;
  int             n_tests = 0;
  int             n_fail = 0;
  logic           rd_en = 1'b0;
  logic [DIR-1:0] rd_a = '0;
  logic [DIR-1:0] rd_b = '0;

  // scoreboard
  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural value of a register right now: newest in-flight writer wins.
  function automatic logic [BUS-1:0] resolve(input logic [DIR-1:0] a);
    if (ZERO_EN && a == '0) return '0;
    if (bus.ex_fwd_we && !bus.ex_fwd_load && bus.ex_fwd_addr == a) return bus.ex_fwd_data;
    if (bus.mem_fwd_we && bus.mem_fwd_addr == a) return bus.mem_fwd_data;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return bank[a];
  endfunction

  function automatic bit load_use(input ins_t i);
    bit hit = 1'b0;
    if (bus.ex_fwd_we && bus.ex_fwd_load) begin
      if (i.use_rs && i.rs == bus.ex_fwd_addr && !(ZERO_EN && i.rs == '0)) hit = 1'b1;
      if (i.use_rt && i.rt == bus.ex_fwd_addr && !(ZERO_EN && i.rt == '0)) hit = 1'b1;
    end
    return hit;
  endfunction

  // driver tasks
  task automatic idle();
    bus.id_valid     = 1'b0;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_use_rs    = 1'b0;
    bus.id_use_rt    = 1'b0;
    bus.id_rd        = '0;
    bus.id_we        = 1'b0;
    bus.id_is_load   = 1'b0;
    bus.ex_fwd_we    = 1'b0;
    bus.ex_fwd_load  = 1'b0;
    bus.ex_fwd_addr  = '0;
    bus.ex_fwd_data  = '0;
    bus.mem_fwd_we   = 1'b0;
    bus.mem_fwd_addr = '0;
    bus.mem_fwd_data = '0;
    bus.wb_we        = 1'b0;
    bus.wb_addr      = '0;
    bus.wb_data      = '0;
    bus.ex_ready     = 1'b1;
  endtask

  task automatic issue(input int rs, input int rt, input int rd, input bit ld);
    bus.id_valid   = 1'b1;
    bus.id_rs      = DIR'(rs);
    bus.id_rt      = DIR'(rt);
    bus.id_use_rs  = 1'b1;
    bus.id_use_rt  = 1'b1;
    bus.id_rd      = DIR'(rd);
    bus.id_we      = 1'b1;
    bus.id_is_load = ld;
  endtask

  // One clock: called at posedge+1 with inputs driven; returns at next posedge+1.
  task automatic tick();
    bit   haz, free, adv, iss;
    ins_t cur, nw;
    #1;
    haz  = (s1_q.size() != 0) && load_use(s1_q[0]);
    free = (exp_q.size() == 0) || bus.ex_ready;
    adv  = (s1_q.size() != 0) && !haz && free;
    iss  = bus.id_valid && ((s1_q.size() == 0) || adv);
    check("id_ready", EW'(bus.id_ready), EW'((s1_q.size() == 0) || adv));
    rd_en = iss || ((s1_q.size() != 0) && !adv);
    check("rf_memread", EW'(bus.rf_memread), EW'(rd_en));
    if (rd_en) begin
      rd_a = iss ? bus.id_rs : s1_q[0].rs;
      rd_b = iss ? bus.id_rt : s1_q[0].rt;
      check("rf_da", EW'(bus.rf_da), EW'(rd_a));
      check("rf_db", EW'(bus.rf_db), EW'(rd_b));
    end
    if (exp_q.size() != 0 && bus.ex_ready) void'(exp_q.pop_front());
    if (adv) begin
      cur = s1_q.pop_front();
      exp_q.push_back({resolve(cur.rs), resolve(cur.rt), cur.rd, cur.we, cur.ld});
    end
    if (iss) begin
      nw = {bus.id_rs, bus.id_rt, bus.id_rd, bus.id_use_rs, bus.id_use_rt,
            bus.id_we, bus.id_is_load};
      s1_q.push_back(nw);
    end
    if (haz && hz_exp != 16'hFFFF) hz_exp++;
    @(negedge clk);
    if (bus.wb_we) bank[bus.wb_addr] = bus.wb_data;
    @(posedge clk);
    #1;
    if (rd_en) begin
      bus.rf_doa = bank[rd_a];
      bus.rf_dob = bank[rd_b];
    end
    check("ex_valid", EW'(bus.ex_valid), EW'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("ex_payload", {bus.ex_opa, bus.ex_opb, bus.ex_rd, bus.ex_we, bus.ex_is_load}, exp_q[0]);
    check("hz_count", EW'(bus.hz_count), EW'(hz_exp));
    check("s1_valid", EW'(bus.dbg_s1_valid), EW'(s1_q.size() != 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, EW'(bus.ex_valid), '0);
    check({tag, "_ex_payload"}, {bus.ex_opa, bus.ex_opb, bus.ex_rd, bus.ex_we, bus.ex_is_load}, '0);
    check({tag, "_hz_count"}, EW'(bus.hz_count), '0);
    check({tag, "_rf_memread"}, EW'(bus.rf_memread), '0);
  endtask

  initial begin
    idle();
    bus.rf_doa = '0;
    bus.rf_dob = '0;
    for (int i = 0; i < 2**DIR; i++) bank[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    rst_n = 1'b1;

    // basic read from the bank, two-edge latency
    bank[3] = 32'h11;
    bank[4] = 32'h22;
    issue(3, 4, 10, 1'b0);
    tick();
    idle();
    tick();
    check("d1_valid", EW'(bus.ex_valid), EW'(1'b1));
    check("d1_ops", EW'({bus.ex_opa, bus.ex_opb}), EW'({32'h11, 32'h22}));
    tick();

    // EX beats MEM
    issue(5, 6, 11, 1'b0);
    tick();
    idle();
    bus.ex_fwd_we = 1'b1; bus.ex_fwd_addr = 5; bus.ex_fwd_data = 32'hAA;
    bus.mem_fwd_we = 1'b1; bus.mem_fwd_addr = 5; bus.mem_fwd_data = 32'hBB;
    tick();
    idle();
    check("d2_ex_prio", EW'(bus.ex_opa), EW'(32'hAA));
    tick();

    // load-use: one bubble, then MEM forwarding
    issue(7, 8, 12, 1'b0);
    tick();
    idle();
    bus.ex_fwd_we = 1'b1; bus.ex_fwd_load = 1'b1; bus.ex_fwd_addr = 7; bus.ex_fwd_data = 32'hDE;
    tick();
    check("d3_bubble", EW'(bus.ex_valid), '0);
    check("d3_hz_one", EW'(bus.hz_count), EW'(16'd1));
    idle();
    bus.mem_fwd_we = 1'b1; bus.mem_fwd_addr = 7; bus.mem_fwd_data = 32'h77;
    tick();
    idle();
    check("d3_load_fwd", EW'(bus.ex_opa), EW'(32'h77));
    tick();
    tick();

    // downstream stall with a WB write to the held source
    bank[9] = 32'h1234;
    issue(1, 2, 13, 1'b0);
    tick();
    issue(9, 2, 14, 1'b0);
    bus.ex_ready = 1'b0;
    tick();
    idle();
    bus.ex_ready = 1'b0;
    bus.wb_we = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'h55;
    tick();
    bus.wb_we = 1'b0;
    tick();
    tick();
    bus.ex_ready = 1'b1;
    tick();
    check("d4_after_stall", EW'({bus.ex_opa, bus.ex_rd}), EW'({32'h55, 5'd14}));
    tick();
    tick();

    // register 0
    bank[0] = 32'h33;
    issue(0, 0, 15, 1'b0);
    tick();
    idle();
    bus.ex_fwd_we = 1'b1; bus.ex_fwd_addr = 0; bus.ex_fwd_data = 32'hFF;
    tick();
    idle();
    check("d5_zero_reg", EW'(bus.ex_opa), ZERO_EN ? EW'(0) : EW'(32'hFF));
    tick();

    // asynchronous reset with both stages occupied
    issue(2, 3, 16, 1'b1);
    tick();
    issue(4, 5, 17, 1'b0);
    bus.ex_ready = 1'b0;
    tick();
    idle();
    bus.ex_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_s1", EW'(bus.dbg_s1_valid), '0);
    s1_q.delete();
    exp_q.delete();
    hz_exp = '0;
    rd_en = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(6, 7, 18, 1'b0);
    tick();
    idle();
    check("rst_lat_1", EW'(bus.ex_valid), '0);
    tick();
    check("rst_lat_2", EW'(bus.ex_valid), EW'(1'b1));
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.id_valid     = ($urandom_range(0, 9) < 7);
      bus.id_rs        = DIR'($urandom_range(0, 7));
      bus.id_rt        = DIR'($urandom_range(0, 7));
      bus.id_use_rs    = $urandom_range(0, 1);
      bus.id_use_rt    = $urandom_range(0, 1);
      bus.id_rd        = DIR'($urandom_range(0, 31));
      bus.id_we        = $urandom_range(0, 1);
      bus.id_is_load   = $urandom_range(0, 1);
      bus.ex_fwd_we    = $urandom_range(0, 1);
      bus.ex_fwd_load  = ($urandom_range(0, 3) == 0);
      bus.ex_fwd_addr  = DIR'($urandom_range(0, 7));
      bus.ex_fwd_data  = $urandom;
      bus.mem_fwd_we   = $urandom_range(0, 1);
      bus.mem_fwd_addr = DIR'($urandom_range(0, 7));
      bus.mem_fwd_data = $urandom;
      bus.wb_we        = $urandom_range(0, 1);
      bus.wb_addr      = DIR'($urandom_range(0, 9));
      bus.wb_data      = $urandom;
      bus.ex_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end

    idle();
    repeat (6) tick();
    check("drained", EW'(exp_q.size() + s1_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
